uart_fifo_reader: RTL and testbench
===================================

UART_FIFO_READER -- requirements
Module: uart_fifo_reader

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 32'd50_000_000: input clock frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_MS, default 10: maximum gap allowed between the high and low byte, in ms.
REQ-003 SHALL have port clk_50m  input  1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port uart_rx_fifo_clk  output  1: read clock for the RX FIFO, driven directly from clk_50m.
REQ-006 SHALL have port uart_rx_fifo_empty  input  1: RX FIFO empty flag.
REQ-007 SHALL have port uart_rx_fifo_req  output  1: read request, one-cycle pulse per byte.
REQ-008 SHALL have port uart_rx_fifo_data  input  8: FIFO read data, valid 1 cycle after req.
REQ-009 SHALL have port word_data  output  16: last assembled word, {hi,lo}, big-endian.
REQ-010 SHALL have port word_valid  output  1: one-cycle pulse when word_data updates.
REQ-011 SHALL have port frame_error  output  1: one-cycle pulse when a high byte is dropped on timeout.
REQ-012 SHALL have port led  output  6: word_data[5:0] of the last valid word.

Function
REQ-013 SHALL implement FSM states IDLE, RD_HI, LAT_HI, WAIT_LO, RD_LO, LAT_LO, DONE.
REQ-014 IDLE: if uart_rx_fifo_empty=0 -> RD_HI, else stay in IDLE; no req issued while empty=1.
REQ-015 RD_HI: assert uart_rx_fifo_req for exactly 1 cycle -> LAT_HI.
REQ-016 LAT_HI: capture uart_rx_fifo_data into the hi register; clear the timeout counter -> WAIT_LO.
REQ-017 WAIT_LO: if empty=0 -> RD_LO; else increment the timeout counter; at TIMEOUT_CYC-1 pulse frame_error, discard hi -> IDLE.
REQ-018 TIMEOUT_CYC SHALL equal (CLK_FREQ/1000)*TIMEOUT_MS; the counter SHALL be 32-bit and saturate-free (it cleared before reaching the terminal count).
REQ-019 If empty falls in the same cycle that the timeout terminal count is reached, the read SHALL win: go to RD_LO, with no frame_error.
REQ-020 RD_LO: 1-cycle req pulse -> LAT_LO; LAT_LO: capture lo -> DONE.
REQ-021 DONE: word_data<= {hi,lo}, led<= lo[5:0], word_valid pulse for 1 cycle -> IDLE.
REQ-022 Minimum latency from empty=0 in IDLE (both bytes present) to word_valid SHALL be 6 cycles.
REQ-023 At most one req SHALL be outstanding; req is never asserted on consecutive cycles.
REQ-024 word_data and led SHALL hold their value between words; word_valid and frame_error SHALL be 0 except during their pulse cycle.
REQ-025 The FSM SHALL recover to IDLE from any illegal encoding on the next cycle.

Reset
REQ-026 While reset=1 at a clk_50m edge: state=IDLE, uart_rx_fifo_req=0, word_data=0, word_valid=0, frame_error=0, led=0, hi/lo registers=0, and the timeout counter=0.
REQ-027 Reset mid-word SHALL discard any partial high byte; no word_valid or frame_error pulse is issued for it.

Structure
REQ-028 State encoding, the TIMEOUT_CYC derivation function and the 16-bit word width SHALL reside in shared package uart_pkg.
REQ-029 No sub-module SHALL be used; the FSM and the timeout counter are inline in uart_fifo_reader.

Verification
REQ-030 FIFO preloaded with 0x12,0x34 -> exactly 2 req pulses; word_data=0x1234, led=6'h34, and one word_valid pulse 6 cycles after empty falls.
REQ-031 Only 0xAB supplied, empty held high for TIMEOUT_CYC cycles (TIMEOUT_MS=1 gives 50_000) -> one frame_error pulse; word_data unchanged; return to IDLE.
REQ-032 0xAB followed by 0xCD arriving exactly at the timeout terminal cycle -> word_data=0xABCD, with no frame_error.
REQ-033 Reset asserted in WAIT_LO after 0x55, then bytes 0x01,0x02 -> word_data=0x0102 (not 0x5501), with no pulse produced during reset.
REQ-034 Eight back-to-back bytes 0x00..0x07 -> words 0x0001, 0x0203, 0x0405, 0x0607, in order; req is never high for 2 consecutive cycles; no req occurs while empty=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART RX FIFO word reader: FSM encoding, word width, timeout sizing.
// No logic; constants and one elaboration-time helper only.
// Not applicable (no handshake).
package uart_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_HI   = 3'd1,
        LAT_HI  = 3'd2,
        WAIT_LO = 3'd3,
        RD_LO   = 3'd4,
        LAT_LO  = 3'd5,
        DONE    = 3'd6
    } state_t;

    // Number of clock cycles the reader waits for a low byte before dropping the high byte.
    function automatic logic [31:0] timeout_cyc(input logic [31:0] clk_freq,
                                                input logic [31:0] timeout_ms);
        return (clk_freq / 32'd1000) * timeout_ms;
    endfunction

endpackage

// File: rtl/uart_fifo_reader.sv
// Pops byte pairs from a UART RX FIFO and assembles them into big-endian 16-bit words.
// Latency: 6 cycles from FIFO non-empty in IDLE to word_valid when both bytes are present.
// Backpressure: reads only while empty=0, one request outstanding; a missing low byte times out.
module uart_fifo_reader
    import uart_pkg::*;
#(
    parameter logic [31:0] CLK_FREQ   = 32'd50_000_000,
    parameter int          TIMEOUT_MS = 10
) (
    input  logic              clk_50m,
    input  logic              reset,
    output logic              uart_rx_fifo_clk,
    input  logic              uart_rx_fifo_empty,
    output logic              uart_rx_fifo_req,
    input  logic [BYTE_W-1:0] uart_rx_fifo_data,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    output logic              frame_error,
    output logic [5:0]        led
);

    localparam logic [31:0] TIMEOUT_CYC = timeout_cyc(CLK_FREQ, 32'(TIMEOUT_MS));

    state_t            state;
    state_t            state_nxt;
    logic [BYTE_W-1:0] hi_byte;
    logic [BYTE_W-1:0] lo_byte;
    logic [31:0]       timeout_cnt;
    logic              timeout_hit;

    assign uart_rx_fifo_clk = clk_50m;

    always_comb begin
        state_nxt        = state;
        uart_rx_fifo_req = 1'b0;
        timeout_hit      = 1'b0;
        case (state)
            IDLE:    if (!uart_rx_fifo_empty) state_nxt = RD_HI;
            RD_HI: begin
                uart_rx_fifo_req = 1'b1;
                state_nxt        = LAT_HI;
            end
            LAT_HI:  state_nxt = WAIT_LO;
            // A low byte arriving on the terminal cycle takes priority over the timeout.
            WAIT_LO: begin
                if (!uart_rx_fifo_empty) begin
                    state_nxt = RD_LO;
                end else if (timeout_cnt == TIMEOUT_CYC - 32'd1) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            RD_LO: begin
                uart_rx_fifo_req = 1'b1;
                state_nxt        = LAT_LO;
            end
            LAT_LO:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            state       <= IDLE;
            hi_byte     <= '0;
            lo_byte     <= '0;
            timeout_cnt <= '0;
            word_data   <= '0;
            word_valid  <= 1'b0;
            frame_error <= 1'b0;
            led         <= '0;
        end else begin
            state       <= state_nxt;
            word_valid  <= (state == DONE);
            frame_error <= timeout_hit;
            case (state)
                LAT_HI: begin
                    hi_byte     <= uart_rx_fifo_data;
                    timeout_cnt <= '0;
                end
                WAIT_LO: begin
                    if (timeout_hit) begin
                        hi_byte     <= '0;
                        timeout_cnt <= '0;
                    end else if (uart_rx_fifo_empty) begin
                        timeout_cnt <= timeout_cnt + 32'd1;
                    end
                end
                LAT_LO:  lo_byte <= uart_rx_fifo_data;
                DONE: begin
                    word_data <= {hi_byte, lo_byte};
                    led       <= lo_byte[5:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_reader.sv
// Bench for uart_fifo_reader: queue-based RX FIFO model, expected-word scoreboard, directed and random traffic.
module tb_uart_fifo_reader;

    localparam logic [31:0] TB_CLK_FREQ = 32'd1_000_000;
    localparam int          TB_MS       = 1;
    localparam int          TC          = int'(TB_CLK_FREQ / 32'd1000) * TB_MS;

    logic        clk_50m;
    logic        reset;
    logic        uart_rx_fifo_clk;
    logic        fifo_empty;
    logic        fifo_req;
    logic [7:0]  fifo_dat;
    logic [15:0] word_data;
    logic        word_valid;
    logic        frame_error;
    logic [5:0]  led;

    uart_fifo_reader #(
        .CLK_FREQ   (TB_CLK_FREQ),
        .TIMEOUT_MS (TB_MS)
    ) dut (
        .clk_50m            (clk_50m),
        .reset              (reset),
        .uart_rx_fifo_clk   (uart_rx_fifo_clk),
        .uart_rx_fifo_empty (fifo_empty),
        .uart_rx_fifo_req   (fifo_req),
        .uart_rx_fifo_data  (fifo_dat),
        .word_data          (word_data),
        .word_valid         (word_valid),
        .frame_error        (frame_error),
        .led                (led)
    );

    initial begin
        clk_50m = 1'b0;
        forever #5 clk_50m = ~clk_50m;
    end

    int          checks = 0;
    int          errors = 0;
    int          req_cnt = 0;
    int          wv_cnt = 0;
    int          fe_cnt = 0;
    logic        prev_req = 1'b0;
    logic [7:0]  fifo_q[$];
    logic [15:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] w);
        push_byte(w[15:8]);
        push_byte(w[7:0]);
        exp_q.push_back(w);
    endtask

    // One cycle: observe mid-cycle, then let the FIFO model answer a request.
    task automatic step();
        logic [15:0] e;
        @(negedge clk_50m);
        if (word_valid) begin
            wv_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("word", 32'(word_data), 32'(e));
                check_val("led", 32'(led), 32'(e[5:0]));
            end else begin
                check_val("unexp_word", 32'(word_valid), 32'd0);
            end
        end
        if (frame_error) fe_cnt++;
        if (fifo_req) begin
            req_cnt++;
            check_val("req_b2b", 32'(prev_req), 32'd0);
            check_val("req_empty", 32'(fifo_empty), 32'd0);
            if (fifo_q.size() > 0) fifo_dat = fifo_q.pop_front();
            else fifo_dat = 8'h00;
        end
        prev_req   = fifo_req;
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < max_cyc) begin
            step();
            n++;
        end
        check_val("drain", 32'(exp_q.size()), 32'd0);
        repeat (4) step();
    endtask

    initial begin
        int n;
        int req0;
        int wv0;
        int fe0;
        logic [7:0] hb;
        logic [7:0] lb;

        reset      = 1'b1;
        fifo_empty = 1'b1;
        fifo_dat   = 8'h00;
        repeat (3) step();
        check_val("rst_word", 32'(word_data), 32'd0);
        check_val("rst_led", 32'(led), 32'd0);
        check_val("rst_wv", 32'(word_valid), 32'd0);
        check_val("rst_fe", 32'(frame_error), 32'd0);
        check_val("rst_req", 32'(fifo_req), 32'd0);
        reset = 1'b0;
        repeat (3) step();

        // Preloaded pair: two requests, one word, 6-cycle latency.
        req0 = req_cnt; wv0 = wv_cnt; n = 0;
        push_word(16'h1234);
        while (wv_cnt == wv0 && n < 50) begin
            step();
            n++;
        end
        check_val("pair_lat", 32'(n - 1), 32'd6);
        repeat (4) step();
        check_val("pair_req", 32'(req_cnt - req0), 32'd2);
        check_val("pair_wv", 32'(wv_cnt - wv0), 32'd1);

        // Lone high byte: frame_error after TC empty cycles in the low-byte wait.
        req0 = req_cnt; wv0 = wv_cnt; fe0 = fe_cnt; n = 0;
        push_byte(8'hAB);
        while (fe_cnt == fe0 && n < TC + 50) begin
            step();
            n++;
        end
        check_val("to_lat", 32'(n), 32'(TC + 3));
        repeat (5) step();
        check_val("to_fe", 32'(fe_cnt - fe0), 32'd1);
        check_val("to_word", 32'(word_data), 32'h1234);
        check_val("to_req", 32'(req_cnt - req0), 32'd1);
        check_val("to_wv", 32'(wv_cnt - wv0), 32'd0);
        check_val("to_idle_fe", 32'(frame_error), 32'd0);

        // Low byte arriving exactly on the terminal cycle wins over the timeout.
        fe0 = fe_cnt;
        push_byte(8'hAB);
        exp_q.push_back(16'hABCD);
        repeat (TC + 2) step();
        push_byte(8'hCD);
        drain(50);
        check_val("edge_fe", 32'(fe_cnt - fe0), 32'd0);
        check_val("edge_word", 32'(word_data), 32'hABCD);

        // Reset while waiting for a low byte discards the high byte.
        wv0 = wv_cnt; fe0 = fe_cnt;
        push_byte(8'h55);
        repeat (5) step();
        reset = 1'b1;
        repeat (2) step();
        check_val("midrst_word", 32'(word_data), 32'd0);
        check_val("midrst_led", 32'(led), 32'd0);
        reset = 1'b0;
        repeat (2) step();
        check_val("midrst_pulses", 32'((wv_cnt - wv0) + (fe_cnt - fe0)), 32'd0);
        push_word(16'h0102);
        drain(50);
        check_val("midrst_after", 32'(word_data), 32'h0102);
        check_val("midrst_fe", 32'(fe_cnt - fe0), 32'd0);

        // Eight back-to-back bytes.
        req0 = req_cnt; wv0 = wv_cnt;
        for (int i = 0; i < 4; i++) push_word({8'(2 * i), 8'(2 * i + 1)});
        drain(100);
        check_val("b2b_req", 32'(req_cnt - req0), 32'd8);
        check_val("b2b_wv", 32'(wv_cnt - wv0), 32'd4);

        // Random bytes with gaps well inside the timeout.
        fe0 = fe_cnt; wv0 = wv_cnt;
        for (int i = 0; i < 16; i++) begin
            hb = 8'($urandom);
            lb = 8'($urandom);
            exp_q.push_back({hb, lb});
            repeat ($urandom_range(0, 12)) step();
            push_byte(hb);
            repeat ($urandom_range(0, 12)) step();
            push_byte(lb);
        end
        drain(400);
        check_val("rand_wv", 32'(wv_cnt - wv0), 32'd16);
        check_val("rand_fe", 32'(fe_cnt - fe0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
